// File: rtl/spi_slave_tx_os.sv
// Oversampled SPI slave transmitter. Raw sclk/cs are synchronised into the
// system clock domain and edge-detected; a small word FIFO feeds a shift
// register whose output end drives a registered miso.
module spi_slave_tx_os #(
  parameter int DATA_W      = 32,
  parameter int CNT_W       = 8,
  parameter int DEPTH       = 2,
  parameter int SYNC_STAGES = 2,
  localparam int LW         = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [CNT_W-1:0]  len,
  input  logic              len_upd,
  input  logic [DATA_W-1:0] data,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic              sclk,
  input  logic              cs,
  output logic              miso,
  output logic              done,
  output logic              underrun,
  output logic              aborted,
  output logic [LW-1:0]     fifo_level
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, ARM, SHIFT} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic                   sclk_prev_q, cs_prev_q;
  logic                   cpol_q, cpol_d, cpha_q, cpha_d;
  logic                   ord_q, ord_d;
  logic [CNT_W-1:0]       len_q, len_d;
  logic [CNT_W-1:0]       wlen_q, wlen_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]      shreg_q, shreg_d;
  logic                   miso_q, miso_d;
  logic                   done_q, done_d;
  logic                   underrun_q, underrun_d;
  logic                   aborted_q, aborted_d;
  logic [LW-1:0]          level_q, level_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0]      fifo_mem [DEPTH];

  logic sclk_s, cs_s, cs_fall, cs_rise, lead, trail, launch;
  logic push, pop, load, empty;

  // Synchroniser shift chains and edge detection on the last two samples
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
    sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    cs_s        = cs_sync_q[SYNC_STAGES-1];
    cs_fall     = cs_prev_q & ~cs_s;
    cs_rise     = ~cs_prev_q & cs_s;
    lead        = (sclk_prev_q == cpol_q) && (sclk_s != cpol_q);
    trail       = (sclk_prev_q != cpol_q) && (sclk_s == cpol_q);
    launch      = cpha_q ? lead : trail;
  end

  // FIFO bookkeeping; ready uses the start-of-cycle level so a full FIFO
  // refuses a push even when a pop happens in the same cycle
  always_comb begin
    empty      = (level_q == '0);
    data_ready = (level_q < LW'(DEPTH));
    push       = data_valid && data_ready;
    pop        = load && !empty;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Transfer FSM next-state: cs rise always wins over a launch edge
  always_comb begin
    state_d    = state_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    ord_d      = ord_q;
    wlen_d     = wlen_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    done_d     = 1'b0;
    underrun_d = 1'b0;
    aborted_d  = 1'b0;
    load       = 1'b0;
    len_d      = len_upd ? ((len > LEN_MAX) ? LEN_MAX : len) : len_q;

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          cpol_d = cpol;
          cpha_d = cpha;
          cnt_d  = '0;
          if (!cpha) begin
            load    = 1'b1;
            state_d = SHIFT;
          end else begin
            state_d = ARM;
          end
        end
      end
      ARM: begin
        if (cs_rise) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (launch) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d   = IDLE;
          cnt_d     = '0;
          aborted_d = (cnt_q != '0);
        end else if (launch) begin
          if (cnt_q == wlen_q) begin
            done_d = 1'b1;
            cnt_d  = '0;
            load   = 1'b1;
          end else begin
            shreg_d = ord_q ? {1'b0, shreg_q[DATA_W-1:1]}
                            : {shreg_q[DATA_W-2:0], 1'b0};
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Word load: an empty FIFO yields an all-zero word and an underrun pulse
    if (load) begin
      shreg_d    = empty ? '0 : fifo_mem[rd_ptr_q];
      underrun_d = empty;
      ord_d      = lsb_first;
      wlen_d     = len_q;
    end

    miso_d = (state_q == SHIFT && !cs_rise)
           ? (ord_q ? shreg_q[0] : shreg_q[DATA_W-1]) : 1'b0;
  end

  // All control state, including synchronisers; reset flushes the FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      ord_q       <= 1'b0;
      len_q       <= LEN_MAX;
      wlen_q      <= LEN_MAX;
      cnt_q       <= '0;
      shreg_q     <= '0;
      miso_q      <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
      aborted_q   <= 1'b0;
      level_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      ord_q       <= ord_d;
      len_q       <= len_d;
      wlen_q      <= wlen_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      miso_q      <= miso_d;
      done_q      <= done_d;
      underrun_q  <= underrun_d;
      aborted_q   <= aborted_d;
      level_q     <= level_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // FIFO storage; contents are don't-care once the pointers are reset
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= data;
  end

  assign miso       = miso_q;
  assign done       = done_q;
  assign underrun   = underrun_q;
  assign aborted    = aborted_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_spi_slave_tx_os.sv
// Directed bench for spi_slave_tx_os: acts as SPI master with a 100 ns
// sclk period against a 10 ns system clock.
module tb_spi_slave_tx_os;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
  logic [7:0]  len = 8'd31;
  logic        len_upd = 1'b0;
  logic [31:0] data = '0;
  logic        data_valid = 1'b0;
  logic        data_ready;
  logic        sclk = 1'b0, cs = 1'b1;
  logic        miso, done, underrun, aborted;
  logic [1:0]  fifo_level;

  int checks = 0, errors = 0;
  int n_done = 0, n_under = 0, n_abort = 0;
  logic [63:0] rx;

  spi_slave_tx_os dut (
    .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
    .len(len), .len_upd(len_upd), .data(data), .data_valid(data_valid),
    .data_ready(data_ready), .sclk(sclk), .cs(cs), .miso(miso), .done(done),
    .underrun(underrun), .aborted(aborted), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  // Pulse counters (counts high cycles of each strobe)
  always @(negedge clk) begin
    if (done)     n_done++;
    if (underrun) n_under++;
    if (aborted)  n_abort++;
  end

  task automatic clr_cnt();
    @(posedge clk);
    n_done = 0; n_under = 0; n_abort = 0; rx = '0;
  endtask

  task automatic push(input logic [31:0] w);
    @(negedge clk); data = w; data_valid = 1'b1;
    @(negedge clk); data_valid = 1'b0;
  endtask

  task automatic set_len(input logic [7:0] v);
    @(negedge clk); len = v; len_upd = 1'b1;
    @(negedge clk); len_upd = 1'b0;
  endtask

  task automatic cs_start(input logic pol, input logic pha);
    @(negedge clk); sclk = pol; cpol = pol; cpha = pha;
    #100 cs = 1'b0;
    #100;
  endtask

  task automatic cs_end();
    #50 cs = 1'b1;
    #100;
  endtask

  // Master clocks nbits bits, sampling miso on the non-launch edge
  task automatic shift_bits(input logic pol, input logic pha, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      if (!pha) begin
        rx = {rx[62:0], miso}; sclk = ~pol;
        #50 sclk = pol;
        #50;
      end else begin
        sclk = ~pol;
        #50 rx = {rx[62:0], miso}; sclk = pol;
        #50;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL rst_miso got %b want 0", miso); end
    checks++; if (done !== 1'b0 || underrun !== 1'b0 || aborted !== 1'b0) begin
      errors++; $display("FAIL rst_pulses got %b%b%b want 000", done, underrun, aborted); end
    checks++; if (fifo_level !== 2'd0) begin errors++; $display("FAIL rst_level got %0d want 0", fifo_level); end
    checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", data_ready); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL post_rst_miso got %b want 0", miso); end
  endtask

  task automatic test_mode0();
    set_len(8'd7);
    clr_cnt();
    push(32'hA500_0000);
    checks++; if (fifo_level !== 2'd1) begin errors++; $display("FAIL m0_level got %0d want 1", fifo_level); end
    cs_start(1'b0, 1'b0);
    shift_bits(1'b0, 1'b0, 8);
    cs_end();
    checks++; if (rx[7:0] !== 8'hA5) begin errors++; $display("FAIL m0_bits got %h want a5", rx[7:0]); end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL m0_done got %0d want 1", n_done); end
    checks++; if (n_under !== 1) begin errors++; $display("FAIL m0_underrun got %0d want 1", n_under); end
    checks++; if (n_abort !== 0) begin errors++; $display("FAIL m0_abort got %0d want 0", n_abort); end
  endtask

  task automatic test_mode3_lsb();
    set_len(8'd15);
    clr_cnt();
    lsb_first = 1'b1;
    push(32'h0000_1234);
    cs_start(1'b1, 1'b1);
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL m3_arm_miso got %b want 0", miso); end
    checks++; if (fifo_level !== 2'd1) begin errors++; $display("FAIL m3_arm_level got %0d want 1", fifo_level); end
    shift_bits(1'b1, 1'b1, 16);
    cs_end();
    lsb_first = 1'b0;
    checks++; if (rx[15:0] !== 16'h2C48) begin errors++; $display("FAIL m3_bits got %h want 2c48", rx[15:0]); end
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL m3_idle_miso got %b want 0", miso); end
  endtask

  task automatic test_back_to_back();
    set_len(8'd7);
    clr_cnt();
    push(32'h3C00_0000);
    push(32'h9600_0000);
    checks++; if (fifo_level !== 2'd2 || data_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_full got lvl %0d rdy %b want 2 0", fifo_level, data_ready); end
    @(negedge clk); data = 32'h5A00_0000; data_valid = 1'b1;
    repeat (3) @(negedge clk);
    data_valid = 1'b0;
    checks++; if (fifo_level !== 2'd2) begin errors++; $display("FAIL b2b_held got %0d want 2", fifo_level); end
    cs_start(1'b0, 1'b0);
    checks++; if (fifo_level !== 2'd1 || data_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_freed got lvl %0d rdy %b want 1 1", fifo_level, data_ready); end
    push(32'h5A00_0000);
    checks++; if (fifo_level !== 2'd2) begin errors++; $display("FAIL b2b_third got %0d want 2", fifo_level); end
    shift_bits(1'b0, 1'b0, 24);
    cs_end();
    checks++; if (rx[23:0] !== 24'h3C965A) begin errors++; $display("FAIL b2b_bits got %h want 3c965a", rx[23:0]); end
    checks++; if (n_done !== 3 || n_under !== 1) begin
      errors++; $display("FAIL b2b_pulses got done %0d und %0d want 3 1", n_done, n_under); end
    checks++; if (fifo_level !== 2'd0) begin errors++; $display("FAIL b2b_drained got %0d want 0", fifo_level); end
  endtask

  task automatic test_underrun();
    clr_cnt();
    cs_start(1'b0, 1'b0);
    checks++; if (n_under !== 1) begin errors++; $display("FAIL ur_start got %0d want 1", n_under); end
    shift_bits(1'b0, 1'b0, 8);
    cs_end();
    checks++; if (rx[7:0] !== 8'h00) begin errors++; $display("FAIL ur_bits got %h want 00", rx[7:0]); end
    checks++; if (n_done !== 1 || n_under !== 2) begin
      errors++; $display("FAIL ur_pulses got done %0d und %0d want 1 2", n_done, n_under); end
  endtask

  task automatic test_abort();
    clr_cnt();
    push(32'hFF00_0000);
    cs_start(1'b0, 1'b0);
    shift_bits(1'b0, 1'b0, 5);
    cs_end();
    checks++; if (rx[4:0] !== 5'h1F) begin errors++; $display("FAIL ab_bits got %h want 1f", rx[4:0]); end
    checks++; if (n_abort !== 1 || n_done !== 0) begin
      errors++; $display("FAIL ab_pulses got abort %0d done %0d want 1 0", n_abort, n_done); end
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL ab_miso got %b want 0", miso); end
    clr_cnt();
    push(32'h8100_0000);
    cs_start(1'b0, 1'b0);
    shift_bits(1'b0, 1'b0, 8);
    cs_end();
    checks++; if (rx[7:0] !== 8'h81 || n_done !== 1) begin
      errors++; $display("FAIL ab_restart got %h done %0d want 81 1", rx[7:0], n_done); end
  endtask

  task automatic test_len();
    set_len(8'd31);
    clr_cnt();
    push(32'h8000_0001);
    push(32'hA000_0000);
    cs_start(1'b0, 1'b0);
    fork
      shift_bits(1'b0, 1'b0, 36);
      begin #1000 set_len(8'd3); end
    join
    cs_end();
    checks++; if (rx[35:0] !== {32'h8000_0001, 4'hA}) begin
      errors++; $display("FAIL len_bits got %h want 80000001a", rx[35:0]); end
    checks++; if (n_done !== 2) begin errors++; $display("FAIL len_done got %0d want 2", n_done); end
    set_len(8'd40);
    clr_cnt();
    push(32'hC0FF_EE01);
    cs_start(1'b0, 1'b0);
    shift_bits(1'b0, 1'b0, 32);
    cs_end();
    checks++; if (rx[31:0] !== 32'hC0FF_EE01) begin errors++; $display("FAIL clamp_bits got %h want c0ffee01", rx[31:0]); end
    checks++; if (n_done !== 1 || n_abort !== 0) begin
      errors++; $display("FAIL clamp_pulses got done %0d abort %0d want 1 0", n_done, n_abort); end
  endtask

  task automatic test_reset_mid();
    set_len(8'd7);
    push(32'h1100_0000);
    push(32'h2200_0000);
    cs_start(1'b0, 1'b0);
    shift_bits(1'b0, 1'b0, 3);
    @(negedge clk); rst = 1'b1; cs = 1'b1; sclk = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (fifo_level !== 2'd0 || data_ready !== 1'b1) begin
      errors++; $display("FAIL rmid_fifo got lvl %0d rdy %b want 0 1", fifo_level, data_ready); end
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL rmid_miso got %b want 0", miso); end
  endtask

  initial begin
    rx = '0;
    test_reset();
    test_mode0();
    test_mode3_lsb();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_len();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_tx_os.md
Name: spi_slave_tx_os

Overview:
Oversampled, parametrised SPI slave transmitter running entirely in the system clock domain. Raw sclk and cs are synchronised and edge-detected, and a small word FIFO feeds a shift register. It supports all four CPOL/CPHA modes, MSB- or LSB-first order and a programmable word length. It sits between the slave's register/OBI side and the miso pad, and reports word completion, underrun and abort.

Parameters:
DATA_W, 32, shift register and FIFO word width
CNT_W, 8, width of len and bit counter; must satisfy 2^CNT_W >= DATA_W
DEPTH, 2, FIFO entries (>=1)
SYNC_STAGES, 2, synchroniser flops on sclk and cs (>=2)

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  synchronous, active-high reset
cpol  in  1  clock polarity, latched at cs fall
cpha  in  1  clock phase, latched at cs fall
lsb_first  in  1  bit order, latched at each word load
len  in  CNT_W  bits-per-word minus 1
len_upd  in  1  one-cycle strobe to latch len
data  in  DATA_W  word to transmit
data_valid  in  1  push request
data_ready  out  1  FIFO not full
sclk  in  1  raw SPI clock (asynchronous)
cs  in  1  raw chip select, active-high deselect (asynchronous)
miso  out  1  registered serial output
done  out  1  one-cycle pulse at word completion
underrun  out  1  one-cycle pulse when a load finds the FIFO empty
aborted  out  1  one-cycle pulse when cs rises mid-word
fifo_level  out  $clog2(DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset: miso=0, done=underrun=aborted=0, fifo_level=0, data_ready=1, state IDLE, bit counter 0, len register DATA_W-1, sclk sync chain=0, cs sync chain=1.
- Sync: sclk and cs pass through SYNC_STAGES flops. Edges are detected by comparing the last two synchronised samples. Leading edge = transition away from the latched cpol level; trailing edge = return to it.
- Launch edge: trailing edge if cpha=0, leading edge if cpha=1.
- len: on len_upd, len_reg<=min(len, DATA_W-1). Takes effect at the next word load; the current word is unaffected.
- FIFO: push when data_valid && data_ready. data_ready = fifo_level<DEPTH, using start-of-cycle level. Simultaneous push and pop on a full FIFO: push is refused (ready=0), pop proceeds.
- Word load: pop the FIFO head into the shift register; word length = len_reg+1. If the FIFO is empty, load all zeros and pulse underrun. Load lsb_first into the order register.
- miso source: shreg[DATA_W-1] for MSB-first, shreg[0] for LSB-first, registered one cycle.
- States: IDLE, ARM, SHIFT.
- IDLE: miso=0.
  - On cs falling (sync), latch cpol/cpha and clear the bit counter.
  - If cpha=0: do a word load, go to SHIFT. The first bit appears on miso the next cycle.
  - If cpha=1: go to ARM.
- ARM: miso=0. On the first launch edge, do a word load and go to SHIFT.
- SHIFT, on each launch edge:
  - If counter==word length-1: pulse done, counter<=0, do a word load (the next word is consumed even if cs then rises).
  - Else: shift one place toward the output end (zero fill), counter+1.
- cs rising (sync) in ARM or SHIFT: go to IDLE, miso<=0, counter<=0. Pulse aborted if counter!=0. No done is issued. FIFO contents are kept.
- Launch edge and cs rise in the same cycle: cs rise wins; no load and no done.
- Edges seen while cs is high are ignored. Changes to cpol/cpha during a transfer are ignored.
- rst at any time, including mid-transfer: return to reset values; the FIFO is flushed.
- Latency:
  - Push to availability: 1 clk.
  - Launch-edge detection: SYNC_STAGES+1 clk after the raw pin edge.
  - miso update: 1 further clk.
  - Requirement: f_clk >= 8 x f_sclk.

Test Plan:
- Mode 0, MSB-first, len=7. Push 0xA5000000, 8 sclk cycles -> miso sequence 1,0,1,0,0,1,0,1; done pulses once at the 8th trailing edge; underrun pulses on the prefetch load.
- Mode 3, LSB-first, len=15. Push 0x00001234 -> bits 0x1234 LSB first, sampled on rising sclk; miso=0 during ARM.
- Push 3 words with DEPTH=2 -> data_ready drops after 2 pushes; third word is held until a load frees a slot, with fifo_level tracking 0->1->2->1.
- FIFO empty at cs fall -> underrun=1 for one clk; miso all zeros for the word; done still pulses.
- cs rises after 5 of 8 bits -> aborted pulse, no done, miso=0, state IDLE. The next cs fall starts a fresh word with the counter at 0.
- len_upd len=3 mid-word during a 32-bit word -> current word completes after 32 bits; the next word completes after 4 bits. len=40 with DATA_W=32 -> clamped to 32 bits.
